mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Shares the single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time, holds it stable on the memory side, and routes the single response back to the requester that owns it.
- Sits between the core front-end/LSU and the bus/memory interface.
- Only one transaction is outstanding at any time.

Parameters:
- AW, 32, address width.
- DW, 32, data width; the write mask is DW/8 bits.
- STARVE_MAX, 4, maximum consecutive LSU grants while IFU is requesting; the next grant is then forced to IFU.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ifu_req_val  in  1  IFU fetch request valid.
- ifu_req_rdy  out  1  IFU request accepted this cycle.
- ifu_req_addr  in  AW  fetch address.
- ifu_flush  in  1  discard any in-flight IFU response (PC redirect).
- ifu_rsp_val  out  1  one-cycle IFU response strobe.
- ifu_rsp_data  out  DW  fetched instruction.
- lsu_req_val  in  1  LSU request valid.
- lsu_req_rdy  out  1  LSU request accepted this cycle.
- lsu_req_addr  in  AW  LSU address.
- lsu_req_wen  in  1  1 = store, 0 = load.
- lsu_req_wdata  in  DW  store data.
- lsu_req_wmask  in  DW/8  byte enables.
- lsu_rsp_val  out  1  one-cycle LSU response strobe.
- lsu_rsp_data  out  DW  load data; returned unchanged for stores.
- mem_req_val  out  1  memory request valid.
- mem_req_rdy  in  1  memory accepts the request.
- mem_req_addr  out  AW  latched address.
- mem_req_wen  out  1  latched write enable; forced to 0 for IFU requests.
- mem_req_wdata  out  DW  latched store data.
- mem_req_wmask  out  DW/8  latched byte mask; 0 for IFU requests.
- mem_rsp_val  in  1  memory response valid; may only occur in WAIT.
- mem_rsp_data  in  DW  memory response data.

Behaviour:
- Reset:
  - Asynchronous on rst=1: state=IDLE, owner=IFU, drop=0, starve_cnt=0.
  - All mem_req_* registers and both *_rsp_val are 0.
  - Reset mid-transaction abandons it; no response is forwarded after reset.
- States: IDLE, REQ, WAIT.
- IDLE:
  - Only state in which *_req_rdy can be 1. Grant is combinational.
  - lsu_req_val=1 and starve_cnt<STARVE_MAX: grant LSU. Otherwise, if ifu_req_val=1 and ifu_flush=0: grant IFU.
  - Never both rdy in the same cycle.
  - Effect of a grant: the granted *_req_rdy=1; addr/wen/wdata/wmask are latched into mem_req_*; owner is recorded; drop=0; next state REQ.
  - No request: stay in IDLE.
  - An IFU request arriving in the same cycle as ifu_flush is not granted that cycle.
- REQ:
  - mem_req_val=1; fields hold stable until mem_req_rdy.
  - mem_req_rdy=1: next state WAIT, mem_req_val deasserts the following cycle.
  - The request is never retracted, even on flush.
- WAIT:
  - mem_req_val=0.
  - On mem_rsp_val=1: the owner's rsp_val=1 for exactly that cycle, rsp_data=mem_rsp_data (combinational pass-through); next state IDLE.
  - Exception: if owner=IFU and (drop=1 or ifu_flush=1 that cycle), the response is consumed silently and ifu_rsp_val stays 0.
- Flush:
  - ifu_flush=1 in REQ or WAIT with owner=IFU sets drop=1.
  - ifu_flush has no effect when owner=LSU.
- Starvation counter:
  - LSU grant while ifu_req_val=1: starve_cnt increments, saturating at STARVE_MAX.
  - Any IFU grant: starve_cnt=0.
  - IDLE with ifu_req_val=0: starve_cnt=0.
  - Width: clog2(STARVE_MAX+1).
- Latency and throughput:
  - Minimum: request accept to response is 2 cycles (rsp_val no earlier than cycle t+2 after rdy at t).
  - Back-to-back throughput: 1 transaction per 3 cycles.
- Response delivery: *_rsp_val are strobes with no back-pressure; requesters must capture them on the same cycle.
- Protocol assertion: mem_rsp_val outside WAIT is a protocol error and is ignored.

Decomposition:
- Package mem_arb_pkg:
  - State encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2).
  - Owner encoding (OWN_IFU=1'b0, OWN_LSU=1'b1).
  - Default STARVE_MAX.
- Sub-module mem_arb_sel: purely combinational grant logic. Inputs are both req_val, ifu_flush, idle and starve_cnt; outputs are gnt_ifu and gnt_lsu (one-hot or zero).
- FSM, latches and counter live in the top module.

Test Plan:
- Single fetch:
  - Stimulus: ifu_req_val=1, addr=0x80000000; mem_req_rdy=1 on the first REQ cycle; mem_rsp_val a cycle later with data 0x00000013.
  - Required: ifu_rsp_val=1 with 0x00000013 exactly 2 cycles after ifu_req_rdy; mem_req_wen=0, wmask=0.
- Store then load:
  - Stimulus: LSU store addr=0x100, wdata=0xDEADBEEF, wmask=0xF, followed by a load.
  - Required: mem_req_* carry exactly those values; lsu_rsp_val pulses once per transaction; ifu_rsp_val stays 0.
- Starvation:
  - Stimulus: both val held high continuously, memory always ready and responding in 1 cycle.
  - Required: grant order is LSU x4, IFU x1, LSU x4, ...
- Flush in WAIT:
  - Stimulus: IFU granted, ifu_flush=1 while in WAIT, response 0x12345678 later.
  - Required: ifu_rsp_val never asserted; state returns to IDLE; the next IFU request is serviced normally.
- Memory stall:
  - Stimulus: mem_req_rdy=0 for 5 cycles while lsu_req_addr changes.
  - Required: mem_req_addr stays at the latched value; no *_req_rdy asserted during the stall.
- Reset mid-WAIT:
  - Stimulus: rst=1 asynchronously between clock edges, then mem_rsp_val=1 after rst releases.
  - Required: all outputs 0 immediately; no rsp_val forwarded; the FSM restarts in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the IFU/LSU memory-port arbiter.
// Imported by the interface-facing top and the grant selector.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of IFU, LSU and memory-side signals around the shared memory port.
// slave = arbiter view, master = surrounding core/memory view.
interface mem_port_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic            ifu_req_val;
  logic            ifu_req_rdy;
  logic [AW-1:0]   ifu_req_addr;
  logic            ifu_flush;
  logic            ifu_rsp_val;
  logic [DW-1:0]   ifu_rsp_data;

  logic            lsu_req_val;
  logic            lsu_req_rdy;
  logic [AW-1:0]   lsu_req_addr;
  logic            lsu_req_wen;
  logic [DW-1:0]   lsu_req_wdata;
  logic [DW/8-1:0] lsu_req_wmask;
  logic            lsu_rsp_val;
  logic [DW-1:0]   lsu_rsp_data;

  logic            mem_req_val;
  logic            mem_req_rdy;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_wen;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wmask;
  logic            mem_rsp_val;
  logic [DW-1:0]   mem_rsp_data;

  modport slave (
    input  ifu_req_val, ifu_req_addr, ifu_flush,
    output ifu_req_rdy, ifu_rsp_val, ifu_rsp_data,
    input  lsu_req_val, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_req_rdy, lsu_rsp_val, lsu_rsp_data,
    output mem_req_val, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_rdy, mem_rsp_val, mem_rsp_data
  );

  modport master (
    output ifu_req_val, ifu_req_addr, ifu_flush,
    input  ifu_req_rdy, ifu_rsp_val, ifu_rsp_data,
    output lsu_req_val, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_req_rdy, lsu_rsp_val, lsu_rsp_data,
    input  mem_req_val, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_rdy, mem_rsp_val, mem_rsp_data
  );

endinterface

// File: rtl/mem_arb_sel.sv
// Combinational grant selection: LSU wins unless it has starved the IFU,
// a flushing IFU request is never granted. Grants are one-hot or zero.
module mem_arb_sel #(
  parameter int STARVE_MAX = 4,
  parameter int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          i_ifu_val,
  input  logic          i_lsu_val,
  input  logic          i_ifu_flush,
  input  logic          i_idle,
  input  logic [CW-1:0] i_starve_cnt,
  output logic          o_gnt_ifu,
  output logic          o_gnt_lsu
);

  logic w_lsu_ok;

  assign w_lsu_ok  = i_starve_cnt < CW'(STARVE_MAX);
  assign o_gnt_lsu = i_idle && i_lsu_val && w_lsu_ok;
  assign o_gnt_ifu = i_idle && !o_gnt_lsu && i_ifu_val && !i_ifu_flush;

endmodule

// File: rtl/mem_port_arb.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU:
// latches the granted request, holds it until accepted, routes the response.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic           clk,
  input logic           rst,
  mem_port_arb_if.slave bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  state_t          r_state;
  state_t          w_next_state;
  owner_t          r_owner;
  logic            r_drop;
  logic [CW-1:0]   r_starve_cnt;
  logic [AW-1:0]   r_addr;
  logic            r_wen;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wmask;

  logic            w_idle;
  logic            w_gnt_ifu;
  logic            w_gnt_lsu;
  logic            w_rsp_fire;

  assign w_idle = (r_state == ST_IDLE);

  mem_arb_sel #(
    .STARVE_MAX (STARVE_MAX),
    .CW         (CW)
  ) u_sel (
    .i_ifu_val    (bus.ifu_req_val),
    .i_lsu_val    (bus.lsu_req_val),
    .i_ifu_flush  (bus.ifu_flush),
    .i_idle       (w_idle),
    .i_starve_cnt (r_starve_cnt),
    .o_gnt_ifu    (w_gnt_ifu),
    .o_gnt_lsu    (w_gnt_lsu)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through the case leaves a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_ifu || w_gnt_lsu) w_next_state = ST_REQ;
      ST_REQ:  if (bus.mem_req_rdy)        w_next_state = ST_WAIT;
      ST_WAIT: if (bus.mem_rsp_val)        w_next_state = ST_IDLE;
      default:                             w_next_state = ST_IDLE;
    endcase
  end

  // A response arriving outside WAIT is a protocol violation and is ignored.
  always_comb begin
    w_rsp_fire       = (r_state == ST_WAIT) && bus.mem_rsp_val;
    bus.ifu_req_rdy  = w_gnt_ifu;
    bus.lsu_req_rdy  = w_gnt_lsu;
    bus.mem_req_val  = (r_state == ST_REQ);
    bus.ifu_rsp_val  = w_rsp_fire && (r_owner == OWN_IFU) && !r_drop && !bus.ifu_flush;
    bus.lsu_rsp_val  = w_rsp_fire && (r_owner == OWN_LSU);
    bus.ifu_rsp_data = bus.mem_rsp_data;
    bus.lsu_rsp_data = bus.mem_rsp_data;
  end

  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_wen   = r_wen;
  assign bus.mem_req_wdata = r_wdata;
  assign bus.mem_req_wmask = r_wmask;

  // Request latch; fetches never carry write data or byte enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_owner <= OWN_IFU;
      r_drop  <= 1'b0;
    end else if (w_gnt_lsu) begin
      r_addr  <= bus.lsu_req_addr;
      r_wen   <= bus.lsu_req_wen;
      r_wdata <= bus.lsu_req_wdata;
      r_wmask <= bus.lsu_req_wmask;
      r_owner <= OWN_LSU;
      r_drop  <= 1'b0;
    end else if (w_gnt_ifu) begin
      r_addr  <= bus.ifu_req_addr;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_owner <= OWN_IFU;
      r_drop  <= 1'b0;
    end else if (!w_idle && (r_owner == OWN_IFU) && bus.ifu_flush) begin
      r_drop  <= 1'b1;
    end
  end

  // Counts LSU wins while the IFU waits; only meaningful in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_idle) begin
      if (!bus.ifu_req_val || w_gnt_ifu)
        r_starve_cnt <= '0;
      else if (w_gnt_lsu && (r_starve_cnt != CW'(STARVE_MAX)))
        r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a cycle-by-cycle vector table plus
// hand-written starvation and asynchronous-reset sequences.
module tb_mem_port_arb;

  localparam logic [31:0] A = 32'h8000_0000;

  typedef struct {
    logic        iv;  logic [31:0] ia; logic fl;
    logic        lv;  logic [31:0] la; logic we; logic [31:0] wd; logic [3:0] wm;
    logic        mr;  logic rv; logic [31:0] rd;
    logic        e_irdy, e_lrdy, e_mval;
    logic [31:0] e_addr; logic e_wen; logic [31:0] e_wdata; logic [3:0] e_wmask;
    logic        e_irsp, e_lrsp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arb_if #(.AW(32), .DW(32)) bus ();

  mem_port_arb #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  vec_t tbl[31];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [31:0] ia, input logic fl,
    input logic lv, input logic [31:0] la, input logic we, input logic [31:0] wd, input logic [3:0] wm,
    input logic mr, input logic rv, input logic [31:0] rd,
    input logic e_irdy, input logic e_lrdy, input logic e_mval,
    input logic [31:0] e_addr, input logic e_wen, input logic [31:0] e_wdata, input logic [3:0] e_wmask,
    input logic e_irsp, input logic e_lrsp);
    vec_t v;
    v.iv = iv; v.ia = ia; v.fl = fl;
    v.lv = lv; v.la = la; v.we = we; v.wd = wd; v.wm = wm;
    v.mr = mr; v.rv = rv; v.rd = rd;
    v.e_irdy = e_irdy; v.e_lrdy = e_lrdy; v.e_mval = e_mval;
    v.e_addr = e_addr; v.e_wen = e_wen; v.e_wdata = e_wdata; v.e_wmask = e_wmask;
    v.e_irsp = e_irsp; v.e_lrsp = e_lrsp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.ifu_req_val   = v.iv;
    bus.ifu_req_addr  = v.ia;
    bus.ifu_flush     = v.fl;
    bus.lsu_req_val   = v.lv;
    bus.lsu_req_addr  = v.la;
    bus.lsu_req_wen   = v.we;
    bus.lsu_req_wdata = v.wd;
    bus.lsu_req_wmask = v.wm;
    bus.mem_req_rdy   = v.mr;
    bus.mem_rsp_val   = v.rv;
    bus.mem_rsp_data  = v.rd;
  endtask

  task automatic drive_idle();
    drive(mk(0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
  endtask

  task automatic check_row(input string tag, input vec_t v);
    check({tag, " ifu_req_rdy"}, 64'(bus.ifu_req_rdy), 64'(v.e_irdy));
    check({tag, " lsu_req_rdy"}, 64'(bus.lsu_req_rdy), 64'(v.e_lrdy));
    check({tag, " mem_req_val"}, 64'(bus.mem_req_val), 64'(v.e_mval));
    if (v.e_mval) begin
      check({tag, " mem_req_addr"},  64'(bus.mem_req_addr),  64'(v.e_addr));
      check({tag, " mem_req_wen"},   64'(bus.mem_req_wen),   64'(v.e_wen));
      check({tag, " mem_req_wdata"}, 64'(bus.mem_req_wdata), 64'(v.e_wdata));
      check({tag, " mem_req_wmask"}, 64'(bus.mem_req_wmask), 64'(v.e_wmask));
    end
    check({tag, " ifu_rsp_val"}, 64'(bus.ifu_rsp_val), 64'(v.e_irsp));
    check({tag, " lsu_rsp_val"}, 64'(bus.lsu_rsp_val), 64'(v.e_lrsp));
    if (v.e_irsp) check({tag, " ifu_rsp_data"}, 64'(bus.ifu_rsp_data), 64'(v.rd));
    if (v.e_lrsp) check({tag, " lsu_rsp_data"}, 64'(bus.lsu_rsp_data), 64'(v.rd));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req_val"},   64'(bus.mem_req_val),   64'd0);
    check({tag, " mem_req_addr"},  64'(bus.mem_req_addr),  64'd0);
    check({tag, " mem_req_wen"},   64'(bus.mem_req_wen),   64'd0);
    check({tag, " mem_req_wdata"}, 64'(bus.mem_req_wdata), 64'd0);
    check({tag, " mem_req_wmask"}, 64'(bus.mem_req_wmask), 64'd0);
    check({tag, " ifu_rsp_val"},   64'(bus.ifu_rsp_val),   64'd0);
    check({tag, " lsu_rsp_val"},   64'(bus.lsu_rsp_val),   64'd0);
    check({tag, " ifu_req_rdy"},   64'(bus.ifu_req_rdy),   64'd0);
    check({tag, " lsu_req_rdy"},   64'(bus.lsu_req_rdy),   64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g_lsu [10];
    logic e_lsu [10];
    int   got;

    // single fetch
    tbl[0]  = mk(1,A,0, 0,0,0,0,0, 0,0,0,                      1,0,0, 0,0,0,0, 0,0);
    tbl[1]  = mk(0,0,0, 0,0,0,0,0, 1,0,0,                      0,0,1, A,0,0,0, 0,0);
    tbl[2]  = mk(0,0,0, 0,0,0,0,0, 0,1,32'h0000_0013,          0,0,0, 0,0,0,0, 1,0);
    // store then load, pending load waits while the store is in flight
    tbl[3]  = mk(0,0,0, 1,32'h100,1,32'hDEAD_BEEF,4'hF, 0,0,0, 0,1,0, 0,0,0,0, 0,0);
    tbl[4]  = mk(0,0,0, 1,32'h104,0,0,0, 1,0,0,                0,0,1, 32'h100,1,32'hDEAD_BEEF,4'hF, 0,0);
    tbl[5]  = mk(0,0,0, 1,32'h104,0,0,0, 0,1,32'hCAFE_0001,    0,0,0, 0,0,0,0, 0,1);
    tbl[6]  = mk(0,0,0, 1,32'h104,0,0,0, 0,0,0,                0,1,0, 0,0,0,0, 0,0);
    tbl[7]  = mk(0,0,0, 0,0,0,0,0, 1,0,0,                      0,0,1, 32'h104,0,0,0, 0,0);
    tbl[8]  = mk(0,0,0, 0,0,0,0,0, 0,1,32'h55AA_55AA,          0,0,0, 0,0,0,0, 0,1);
    // memory stall while requesters keep changing their inputs
    tbl[9]  = mk(0,0,0, 1,32'h200,1,32'h1111_1111,4'h3, 0,0,0, 0,1,0, 0,0,0,0, 0,0);
    for (int i = 0; i < 5; i++)
      tbl[10+i] = mk(1,A+32'h40,0, 1,32'h300+32'(4*i),0,0,0, 0,0,0,
                     0,0,1, 32'h200,1,32'h1111_1111,4'h3, 0,0);
    tbl[15] = mk(1,A+32'h40,0, 1,32'h314,0,0,0, 1,0,0,         0,0,1, 32'h200,1,32'h1111_1111,4'h3, 0,0);
    tbl[16] = mk(1,A+4,0, 0,0,0,0,0, 0,1,32'h0,                0,0,0, 0,0,0,0, 0,1);
    // flush in WAIT drops the response; flush blocks a same-cycle grant
    tbl[17] = mk(1,A+4,0, 0,0,0,0,0, 0,0,0,                    1,0,0, 0,0,0,0, 0,0);
    tbl[18] = mk(0,0,0, 0,0,0,0,0, 1,0,0,                      0,0,1, A+4,0,0,0, 0,0);
    tbl[19] = mk(0,0,1, 0,0,0,0,0, 0,0,0,                      0,0,0, 0,0,0,0, 0,0);
    tbl[20] = mk(0,0,0, 0,0,0,0,0, 0,1,32'h1234_5678,          0,0,0, 0,0,0,0, 0,0);
    tbl[21] = mk(1,A+8,1, 0,0,0,0,0, 0,1,32'h0BAD_F00D,        0,0,0, 0,0,0,0, 0,0);
    tbl[22] = mk(1,A+8,0, 0,0,0,0,0, 0,0,0,                    1,0,0, 0,0,0,0, 0,0);
    tbl[23] = mk(0,0,0, 0,0,0,0,0, 1,0,0,                      0,0,1, A+8,0,0,0, 0,0);
    tbl[24] = mk(0,0,0, 0,0,0,0,0, 0,1,32'h0010_0073,          0,0,0, 0,0,0,0, 1,0);
    // flush is ignored when the LSU owns the port
    tbl[25] = mk(0,0,0, 1,32'h400,0,0,0, 0,0,0,                0,1,0, 0,0,0,0, 0,0);
    tbl[26] = mk(0,0,1, 0,0,0,0,0, 1,0,0,                      0,0,1, 32'h400,0,0,0, 0,0);
    tbl[27] = mk(0,0,1, 0,0,0,0,0, 0,1,32'h7654_3210,          0,0,0, 0,0,0,0, 0,1);
    // flush coinciding with the response cycle
    tbl[28] = mk(1,A+12,0, 0,0,0,0,0, 0,0,0,                   1,0,0, 0,0,0,0, 0,0);
    tbl[29] = mk(0,0,0, 0,0,0,0,0, 1,0,0,                      0,0,1, A+12,0,0,0, 0,0);
    tbl[30] = mk(0,0,1, 0,0,0,0,0, 0,1,32'h1122_3344,          0,0,0, 0,0,0,0, 0,0);

    drive_idle();
    rst = 1'b1;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      drive(tbl[i]);
      #2;
      check_row($sformatf("row%0d", i), tbl[i]);
      @(negedge clk);
    end

    // starvation: both requesters always valid, memory always ready
    e_lsu = '{1,1,1,1,0,1,1,1,1,0};
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      drive(mk(1,A+32'h80,0, 1,32'h500,1,32'hA5A5_A5A5,4'hF, 1,1,32'h99, 0,0,0, 0,0,0,0, 0,0));
      #2;
      if (bus.ifu_req_rdy && bus.lsu_req_rdy)
        $display("FAIL starve both_rdy: got 0x1 expected 0x0 at cycle %0d", cyc);
      if (bus.ifu_req_rdy || bus.lsu_req_rdy) begin
        g_lsu[got] = bus.lsu_req_rdy;
        got++;
      end
      @(negedge clk);
    end
    check("starve grant_count", 64'(got), 64'd10);
    for (int k = 0; k < 10; k++)
      if (k < got) check($sformatf("starve grant%0d is_lsu", k), 64'(g_lsu[k]), 64'(e_lsu[k]));

    // drain the last transaction back to IDLE
    drive(mk(0,0,0, 0,0,0,0,0, 1,1,32'h0, 0,0,0, 0,0,0,0, 0,0));
    repeat (3) @(negedge clk);
    drive_idle();

    // asynchronous reset while waiting for a fetch response
    drive(mk(1,A+32'h100,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    #2;
    check("rst_seq ifu_req_rdy", 64'(bus.ifu_req_rdy), 64'd1);
    @(negedge clk);
    drive(mk(0,0,0, 0,0,0,0,0, 1,0,0, 0,0,0, 0,0,0,0, 0,0));
    #2;
    check("rst_seq mem_req_addr", 64'(bus.mem_req_addr), 64'(A + 32'h100));
    @(negedge clk);
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(mk(0,0,0, 0,0,0,0,0, 0,1,32'hDEAD_0000, 0,0,0, 0,0,0,0, 0,0));
      #2;
      check($sformatf("post_rst%0d ifu_rsp_val", k), 64'(bus.ifu_rsp_val), 64'd0);
      check($sformatf("post_rst%0d lsu_rsp_val", k), 64'(bus.lsu_rsp_val), 64'd0);
      @(negedge clk);
    end
    drive(mk(1,A+32'h200,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
    #2;
    check("post_rst ifu_req_rdy", 64'(bus.ifu_req_rdy), 64'd1);
    @(negedge clk);
    drive(mk(0,0,0, 0,0,0,0,0, 1,0,0, 0,0,0, 0,0,0,0, 0,0));
    #2;
    check("post_rst mem_req_addr", 64'(bus.mem_req_addr), 64'(A + 32'h200));
    @(negedge clk);
    drive(mk(0,0,0, 0,0,0,0,0, 0,1,32'h0000_0093, 0,0,0, 0,0,0,0, 0,0));
    #2;
    check("post_rst ifu_rsp_val",  64'(bus.ifu_rsp_val),  64'd1);
    check("post_rst ifu_rsp_data", 64'(bus.ifu_rsp_data), 64'h0000_0093);
    @(negedge clk);
    drive_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
